// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes: LANES bytes per cycle through shared inverse S-boxes.
// Optional macro SUBBYTES_SHUFFLE_EN rotates the byte-group order from an LFSR-chosen start.

module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] c
);
  localparam logic [7:0] TBL [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign c = TBL[a];
endmodule

// state | meaning
// IDLE  | waiting for a block, in_ready high
// RUN   | substituting one byte group per cycle in place
// DONE  | result held on state_out until out_ready
module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
`ifdef SUBBYTES_SHUFFLE_EN
  ,
  input  logic [15:0]  seed_in,
  input  logic         seed_load
`endif
);
  localparam int NGRP = 16 / LANES;
  localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NGRP - 1);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]    state;
  logic [127:0]  state_buf;
  logic [127:0]  buf_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] grp;
  logic [7:0]    sb_in  [LANES];
  logic [7:0]    sb_out [LANES];
  logic          accept;

  assign accept    = (state == IDLE) && in_valid;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign state_out = state_buf;

`ifdef SUBBYTES_SHUFFLE_EN
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  logic [15:0]   lfsr;
  logic [CW-1:0] start_q;
  logic          lfsr_fb;

  // Taps 16,14,13,11 of the Fibonacci form
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr    <= LFSR_INIT;
      start_q <= '0;
    end else begin
      if (seed_load)
        lfsr <= (seed_in == 16'h0000) ? LFSR_INIT : seed_in;
      else if (accept)
        lfsr <= {lfsr[14:0], lfsr_fb};
      if (accept)
        start_q <= (NGRP > 1) ? lfsr[CW-1:0] : '0;
    end
  end

  // NGRP is a power of two, so the CW-bit add wraps modulo NGRP
  assign grp = start_q + cnt;
`else
  assign grp = cnt;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign sb_in[l] = state_buf[8*(int'(grp)*LANES + l) +: 8];
    inv_sbox u_inv_sbox (
      .a (sb_in[l]),
      .c (sb_out[l])
    );
  end

  always_comb begin
    buf_nxt = state_buf;
    for (int l = 0; l < LANES; l++)
      buf_nxt[8*(int'(grp)*LANES + l) +: 8] = sb_out[l];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      state_buf <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state_buf <= state_in;
            cnt       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          state_buf <= buf_nxt;
          cnt       <= cnt + 1'b1;
          if (cnt == CNT_LAST)
            state <= DONE;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed and random checks of inv_sub_bytes_seq against an algebraic inverse S-box model.
module tb_inv_sub_bytes_seq;
  localparam int LANES = 4;
  localparam int NGRP  = 16 / LANES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] state_in = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] state_out;
`ifdef SUBBYTES_SHUFFLE_EN
  logic [15:0]  seed_in = '0;
  logic         seed_load = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  inv_sub_bytes_seq #(.LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
`ifdef SUBBYTES_SHUFFLE_EN
    ,
    .seed_in   (seed_in),
    .seed_load (seed_load)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Inverse affine map, then multiplicative inverse as x^254
  function automatic logic [7:0] ref_byte(input logic [7:0] s);
    logic [7:0] b;
    logic [7:0] r;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    r = 8'h01;
    if (b == 8'h00) return 8'h00;
    for (int i = 0; i < 254; i++) r = gf_mul(r, b);
    return r;
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[i*8 +: 8] = ref_byte(s[i*8 +: 8]);
    return o;
  endfunction

  task automatic accept(input logic [127:0] d);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1'b1);
    state_in = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    int k;
    k = 0;
    lat = -1;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 1'b0);
    check("in_ready_back", in_ready, 1'b1);
  endtask

  task automatic run_block(input string tag, input logic [127:0] d, input logic [127:0] exp);
    int lat;
    accept(d);
    wait_out(lat);
    check({tag, "_latency"}, lat, NGRP);
    check(tag, state_out, exp);
    release_out();
  endtask

  logic [127:0] v_mix, e_mix, snap, d;
  int lat, acc, prev_acc, per_min, per_max;

  initial begin
    v_mix = '0;
    v_mix[7:0]     = 8'h7c;
    v_mix[47:40]   = 8'h76;
    v_mix[127:120] = 8'hff;
    e_mix = {16{8'h52}};
    e_mix[7:0]     = 8'h01;
    e_mix[47:40]   = 8'h0f;
    e_mix[127:120] = 8'h7d;

    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state_out", state_out, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_block("blk63", {16{8'h63}}, '0);
    run_block("blk00", '0, {16{8'h52}});
    run_block("blk_mix", v_mix, e_mix);

    // DONE stall with a competing input held
    accept('0);
    wait_out(lat);
    check("stall_latency", lat, NGRP);
    snap = state_out;
    state_in = {16{8'h63}};
    in_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("stall_out_valid", out_valid, 1'b1);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_stable", state_out, snap);
    check("stall_value", state_out, {16{8'h52}});
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_ov_drop", out_valid, 1'b0);
    check("stall_idle", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("second_accepted", busy, 1'b1);
    wait_out(lat);
    check("second_latency", lat, NGRP);
    check("second_value", state_out, '0);
    release_out();

    // Reset while cnt==2 in RUN
    accept({16{8'h63}});
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_state_out", state_out, '0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_block("after_rst", v_mix, e_mix);

    // Back-to-back random blocks with out_ready held high
    out_ready = 1'b1;
    prev_acc = -1;
    per_min = 1000;
    per_max = 0;
    for (int i = 0; i < 100; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      state_in = d;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      acc = cyc;
      if (prev_acc >= 0) begin
        if (acc - prev_acc < per_min) per_min = acc - prev_acc;
        if (acc - prev_acc > per_max) per_max = acc - prev_acc;
      end
      prev_acc = acc;
      wait_out(lat);
      check("b2b_latency", lat, NGRP);
      check("b2b_data", state_out, ref_state(d));
    end
    check("b2b_period_min", per_min, NGRP + 2);
    check("b2b_period_max", per_max, NGRP + 2);
    @(negedge clk);
    out_ready = 1'b0;

`ifdef SUBBYTES_SHUFFLE_EN
    @(negedge clk);
    seed_in = 16'h0001;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      run_block("shuf_data", d, ref_state(d));
    end
    @(negedge clk);
    seed_in = 16'h0000;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    run_block("shuf_zero_seed", v_mix, e_mix);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
Iterative AES InvSubBytes unit for the decryption datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through shared inverse S-box lookups. It returns the transformed state over a second valid/ready handshake. It trades latency for area against the fully parallel forward SubBytes stage, and can optionally randomise the byte-group processing order as a side-channel countermeasure.

Parameters:
LANES, 4, inverse S-box instances and bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
NGRP, 16/LANES (derived, not overridable), number of byte groups and RUN cycles per block.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  state_in is valid
in_ready  output  1  unit can accept a block
state_in  input  128  ciphertext-side state; byte i = state_in[i*8 +: 8]
out_valid  output  1  state_out holds a complete result
out_ready  input  1  downstream accepts the result
state_out  output  128  InvSubBytes(state_in); byte i = state_out[i*8 +: 8]
busy  output  1  high in RUN or DONE
seed_in  input  16  LFSR seed (only with SUBBYTES_SHUFFLE_EN)
seed_load  input  1  load seed_in into LFSR (only with SUBBYTES_SHUFFLE_EN)

Behaviour:
- Single 128-bit working register buf drives state_out directly. There are also a group counter cnt and a 2-bit FSM.
- Byte substitution uses a combinational inverse S-box module, inv_sbox (a[7:0] -> c[7:0]), instantiated LANES times.
- Reset values: FSM=IDLE, buf=0, cnt=0, out_valid=0, busy=0, in_ready=1. The LFSR resets to 16'hACE1.
- IDLE:
  - in_ready=1.
  - On in_valid: buf<=state_in, cnt<=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, group g = order(cnt) is replaced in place: buf bytes g*LANES..g*LANES+LANES-1 <= inv_sbox of those bytes. Then cnt<=cnt+1.
  - When cnt==NGRP-1, go to DONE after this cycle's write.
- DONE:
  - out_valid=1 and buf is stable.
  - On out_ready, go to IDLE.
  - out_valid and out_ready are registered decisions: out_valid drops the cycle after the handshake.
- Latency: when the input handshake occurs at edge T, out_valid is high from edge T+NGRP (4 cycles with default LANES). Throughput is one block per NGRP+2 cycles.
- No overlap: in_ready is 0 in RUN and DONE. in_valid is ignored there and the upstream must hold its data.
- out_ready held low in DONE: the unit stalls indefinitely and state_out does not change.
- out_ready asserted outside DONE has no effect.
- state_out is defined only while out_valid=1. In RUN it shows partially substituted data.
- Reset asserted mid-RUN or in DONE: the block is discarded and all outputs return to their reset values asynchronously.
- Each byte is substituted exactly once per block. No byte is skipped or processed twice for any order.

Optional Feature:
SUBBYTES_SHUFFLE_EN
- Defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) advances one step per accepted input block.
  - On the acceptance edge, start = lfsr[log2(NGRP)-1:0] is latched. The processing order is then order(cnt) = (start+cnt) mod NGRP.
  - seed_load loads seed_in in any state; a zero seed loads 16'hACE1 instead.
  - Result values and latency are identical to the unshuffled build.
- Undefined:
  - order(cnt)=cnt, starting at group 0.
  - seed_in and seed_load are absent, and no LFSR is built.

Test Plan:
- Reset, then state_in=128'h63636363_63636363_63636363_63636363 with in_valid for 1 cycle -> out_valid high exactly 4 cycles after acceptance; state_out=128'h0.
- state_in=128'h0 -> state_out=128'h52525252_52525252_52525252_52525252. Bytes 0x7C, 0x76 and 0xFF map to 0x01, 0x0F and 0x7D respectively, and each lands in its original byte lane.
- Hold out_ready=0 for 10 cycles in DONE while driving a new in_valid -> state_out stable, in_ready=0, second block not accepted. After out_ready=1, out_valid drops next cycle and the second block is accepted in IDLE.
- Assert rst_n=0 at cnt=2 of RUN -> out_valid=0, state_out=0, in_ready=1 immediately. A fresh block afterwards produces the correct result.
- Back-to-back: 100 random states with out_ready=1 -> each output equals the reference model, one result per 6 cycles (LANES=4). LANES=1 variant shows 16-cycle latency.
- SUBBYTES_SHUFFLE_EN: seed_load with seed_in=16'h0001, then 8 blocks -> outputs bit-identical to the unshuffled build. Probes on group writes show a varying start group and every group written once per block. seed_in=0 yields the 16'hACE1 sequence.
